// File: rtl/toom8_pkg.sv
// Shared Toom-8 parameters: limb geometry, accumulator sizing and recomposer FSM states.
package toom8_pkg;

  localparam int unsigned LIMB_W = 128;
  localparam int unsigned N_COEF = 15;
  localparam int unsigned COEF_W = 264;
  localparam int unsigned PROD_W = 2 * 8 * LIMB_W;
  // Headroom so the worst-case partial sum never wraps.
  localparam int unsigned ACC_W  = PROD_W + COEF_W - LIMB_W + 4;
  localparam int unsigned IDX_W  = $clog2(N_COEF);

  typedef logic [0:0] state_t;
  localparam state_t ST_ACCUM  = 1'b0;
  localparam state_t ST_OUTPUT = 1'b1;

endpackage

// File: rtl/toom8_shift_add.sv
// Combinational datapath: acc + sign_extend(coef) << (LIMB_W * index).
module toom8_shift_add #(
  parameter int unsigned LIMB_W = 128,
  parameter int unsigned COEF_W = 264,
  parameter int unsigned ACC_W  = 2188,
  parameter int unsigned IDX_W  = 4
) (
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [COEF_W-1:0] coef,
  input  logic        [IDX_W-1:0]  index,
  output logic signed [ACC_W-1:0]  sum
);

  logic signed [ACC_W-1:0] coef_ext;

  assign coef_ext = {{(ACC_W - COEF_W){coef[COEF_W-1]}}, coef};
  assign sum      = acc + (coef_ext << (LIMB_W * index));

endmodule

// File: rtl/toom8_recompose.sv
// Toom-8 recomposition: accumulates N_COEF signed coefficients at limb offsets into one product.
module toom8_recompose #(
  parameter int unsigned LIMB_W = toom8_pkg::LIMB_W,
  parameter int unsigned N_COEF = toom8_pkg::N_COEF,
  parameter int unsigned COEF_W = toom8_pkg::COEF_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    coef_valid,
  output logic                    coef_ready,
  input  logic [COEF_W-1:0]       coef_data,
  output logic                    prod_valid,
  input  logic                    prod_ready,
  output logic [2*8*LIMB_W-1:0]   product,
  output logic                    prod_err
);
  import toom8_pkg::*;

  localparam int unsigned PW = 2 * 8 * LIMB_W;
  localparam int unsigned AW = PW + COEF_W - LIMB_W + 4;
  localparam int unsigned IW = $clog2(N_COEF);

  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [AW-1:0] sum;

  toom8_shift_add #(
    .LIMB_W (LIMB_W),
    .COEF_W (COEF_W),
    .ACC_W  (AW),
    .IDX_W  (IW)
  ) u_shift_add (
    .acc   (acc_q),
    .coef  (coef_data),
    .index (idx_q),
    .sum   (sum)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    if (state_q == ST_ACCUM) begin
      if (coef_valid) begin
        acc_d = sum;
        if (idx_q == IW'(N_COEF - 1)) begin
          idx_d   = '0;
          state_d = ST_OUTPUT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
    end else if (prod_ready) begin
      acc_d   = '0;
      state_d = ST_ACCUM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACCUM;
      idx_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
    end
  end

  assign coef_ready = (state_q == ST_ACCUM);
  assign prod_valid = (state_q == ST_OUTPUT);
  assign product    = acc_q[PW-1:0];
  // Any set bit above the product field means negative or >= 2^PW.
  assign prod_err   = prod_valid && (acc_q[AW-1:PW] != '0);

endmodule

// File: tb/tb_toom8_recompose.sv
// Directed and random-product checks for toom8_recompose, including stalls, gaps and resets.
module tb_toom8_recompose;

  logic                clk = 1'b0;
  logic                rst;
  logic                coef_valid;
  logic                coef_ready;
  logic [263:0]        coef_data;
  logic                prod_valid;
  logic                prod_ready;
  logic [2047:0]       product;
  logic                prod_err;

  int n_chk  = 0;
  int n_fail = 0;

  logic [263:0] cf [15];

  typedef struct packed {
    logic [3:0]    k0;
    logic [263:0]  v0;
    logic [3:0]    k1;
    logic [263:0]  v1;
    logic [2047:0] exp_prod;
    logic          exp_err;
  } vec_t;

  vec_t  vecs   [7];
  string vnames [7];

  toom8_recompose dut (
    .clk        (clk),
    .rst        (rst),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .coef_data  (coef_data),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .product    (product),
    .prod_err   (prod_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [2047:0] act, input logic [2047:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got hi=%h lo=%h, expected hi=%h lo=%h", name,
               act[2047:1984], act[63:0], exp[2047:1984], exp[63:0]);
    end
  endtask

  function automatic logic [263:0] junk();
    logic [263:0] j;
    for (int w = 0; w < 9; w++) j[w*32 +: 32] = $urandom();
    return j;
  endfunction

  // Sends cf[0..n-1]; each negedge drive is followed by one posedge transfer.
  task automatic send_coefs(input int n, input int gap_pct);
    for (int k = 0; k < n; k++) begin
      while ($urandom_range(99) < gap_pct) begin
        coef_valid = 1'b0;
        coef_data  = junk();
        @(negedge clk);
      end
      if (k == n - 1) chk("no_valid_mid_frame", 2048'(prod_valid), 2048'(0));
      coef_valid = 1'b1;
      coef_data  = cf[k];
      @(negedge clk);
    end
    coef_valid = 1'b0;
    coef_data  = junk();
  endtask

  task automatic run_frame(input int gap_pct, input int stall_pct, input logic [2047:0] exp_p,
                           input logic exp_e, input string name);
    int stalls;
    bit done;
    send_coefs(15, gap_pct);
    chk({name, "_latency"}, 2048'(prod_valid), 2048'(1));
    stalls = 0;
    done   = 1'b0;
    while (!done) begin
      chk({name, "_valid"},      2048'(prod_valid), 2048'(1));
      chk({name, "_coef_ready"}, 2048'(coef_ready), 2048'(0));
      chk({name, "_product"},    product, exp_p);
      chk({name, "_err"},        2048'(prod_err), 2048'(exp_e));
      if (stalls < 8 && $urandom_range(99) < stall_pct) begin
        prod_ready = 1'b0;
        stalls++;
      end else begin
        prod_ready = 1'b1;
        done       = 1'b1;
      end
      @(negedge clk);
    end
    prod_ready = 1'b0;
    chk({name, "_ready_after"}, 2048'(coef_ready), 2048'(1));
    chk({name, "_idle_after"},  2048'(prod_valid), 2048'(0));
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [1023:0] x, y;
  logic [2047:0] exp_xy;
  logic [263:0]  csum;

  initial begin
    vecs[0] = '{k0: 4'd0,  v0: 264'd1, k1: 4'd15, v1: '0,
                exp_prod: 2048'd1, exp_err: 1'b0};
    vecs[1] = '{k0: 4'd14, v0: 264'd1, k1: 4'd15, v1: '0,
                exp_prod: 2048'd1 << 1792, exp_err: 1'b0};
    vecs[2] = '{k0: 4'd0,  v0: 264'd1 << 128, k1: 4'd1, v1: {264{1'b1}},
                exp_prod: '0, exp_err: 1'b0};
    vecs[3] = '{k0: 4'd0,  v0: {264{1'b1}}, k1: 4'd15, v1: '0,
                exp_prod: {2048{1'b1}}, exp_err: 1'b1};
    vecs[4] = '{k0: 4'd1,  v0: {264{1'b1}}, k1: 4'd2, v1: 264'd1,
                exp_prod: (2048'd1 << 256) - (2048'd1 << 128), exp_err: 1'b0};
    vecs[5] = '{k0: 4'd14, v0: 264'd1 << 256, k1: 4'd15, v1: '0,
                exp_prod: '0, exp_err: 1'b1};
    vecs[6] = '{k0: 4'd14, v0: (264'd1 << 256) - 264'd1, k1: 4'd15, v1: '0,
                exp_prod: {{256{1'b1}}, {1792{1'b0}}}, exp_err: 1'b0};
    vnames = '{"c0_one", "c14_one", "carry_borrow", "neg_one", "limb_borrow",
               "overflow_top", "max_top"};

    rst        = 1'b1;
    coef_valid = 1'b0;
    coef_data  = '0;
    prod_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_valid",   2048'(prod_valid), 2048'(0));
    chk("reset_ready",   2048'(coef_ready), 2048'(1));
    chk("reset_product", product, '0);
    chk("reset_err",     2048'(prod_err), 2048'(0));
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < 15; k++) cf[k] = '0;
      if (vecs[i].k0 < 4'd15) cf[vecs[i].k0] = vecs[i].v0;
      if (vecs[i].k1 < 4'd15) cf[vecs[i].k1] = vecs[i].v1;
      run_frame(0, 0, vecs[i].exp_prod, vecs[i].exp_err, vnames[i]);
    end

    // Schoolbook limb convolution against a direct wide multiply.
    for (int f = 0; f < 3; f++) begin
      for (int w = 0; w < 32; w++) begin
        x[w*32 +: 32] = $urandom();
        y[w*32 +: 32] = $urandom();
      end
      for (int k = 0; k < 15; k++) begin
        csum = '0;
        for (int i = 0; i < 8; i++) begin
          if (k - i >= 0 && k - i < 8)
            csum += {136'b0, x[i*128 +: 128]} * {136'b0, y[(k-i)*128 +: 128]};
        end
        cf[k] = csum;
      end
      exp_xy = {1024'b0, x} * {1024'b0, y};
      run_frame(30, 40, exp_xy, 1'b0, "random_xy");
    end

    for (int k = 0; k < 15; k++) cf[k] = junk();
    send_coefs(7, 0);
    pulse_reset();
    for (int c = 0; c < 3; c++) begin
      chk("abort_no_product", 2048'(prod_valid), 2048'(0));
      @(negedge clk);
    end
    for (int k = 0; k < 15; k++) cf[k] = '0;
    cf[0] = 264'd5;
    run_frame(0, 0, 2048'd5, 1'b0, "after_abort");

    cf[0] = 264'd3;
    send_coefs(15, 0);
    chk("output_abort_valid", 2048'(prod_valid), 2048'(1));
    prod_ready = 1'b1;
    pulse_reset();
    prod_ready = 1'b0;
    chk("output_abort_cleared", 2048'(prod_valid), 2048'(0));
    chk("output_abort_ready",   2048'(coef_ready), 2048'(1));
    cf[0] = 264'd9;
    run_frame(0, 0, 2048'd9, 1'b0, "after_output_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
